// File: rtl/rhd_pkg.sv
// Shared constants for the RHD2000-style SPI responder: command opcodes,
// FSM state encoding, frame length and the read-only identification ROM.
package rhd_pkg;

  // Command opcodes carried in bits [15:14] of a command frame
  localparam logic [1:0] CMD_CONVERT = 2'b00;
  localparam logic [1:0] CMD_CALIB   = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_READ    = 2'b11;

  // Number of SCK rising edges in a well-formed frame
  localparam int FRAME_BITS = 16;

  // Bit counter stops here so any overlong frame still reads as "not 16"
  localparam logic [4:0] BIT_CNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rhd_state_e;

  // Read-only identification registers ("INTAN" plus chip id)
  localparam logic [5:0] ROM_ADDR_I  = 6'd40;
  localparam logic [5:0] ROM_ADDR_N0 = 6'd41;
  localparam logic [5:0] ROM_ADDR_T  = 6'd42;
  localparam logic [5:0] ROM_ADDR_A  = 6'd43;
  localparam logic [5:0] ROM_ADDR_N1 = 6'd44;
  localparam logic [5:0] ROM_ADDR_ID = 6'd63;

  localparam logic [7:0] ROM_VAL_I = 8'h49;
  localparam logic [7:0] ROM_VAL_N = 8'h4E;
  localparam logic [7:0] ROM_VAL_T = 8'h54;
  localparam logic [7:0] ROM_VAL_A = 8'h41;

  // Value of a read-only register; unmapped addresses read as zero
  function automatic logic [7:0] rom_value(input logic [5:0] addr,
                                           input logic [7:0] chip_id);
    logic [7:0] v;
    v = 8'h00;
    case (addr)
      ROM_ADDR_I:  v = ROM_VAL_I;
      ROM_ADDR_N0: v = ROM_VAL_N;
      ROM_ADDR_T:  v = ROM_VAL_T;
      ROM_ADDR_A:  v = ROM_VAL_A;
      ROM_ADDR_N1: v = ROM_VAL_N;
      ROM_ADDR_ID: v = chip_id;
      default:     v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rhd_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, followed by a delay flop
// used to produce single-cycle rise/fall pulses. The synchronizer resets
// to 0, so a pin that is high when reset releases shows up as a rise.
module rhd_sync_edge
  import rhd_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  // Synchronize the pin and keep one cycle of history for edge detection
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/rhd_spi_responder.sv
// SPI responder emulating the amplifier end of an RHD2000 link. Receives
// 16-bit CS-framed commands, executes CONVERT/READ/WRITE/CALIBRATE and
// returns each frame's result on MISO two frames later.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | CS high; waiting for CS fall (only honoured when armed)
// ST_SHIFT | CS low; shifting command in on SCK rise, result out on fall
// ST_DONE  | one cycle after CS rise; commit a 16-bit frame or flag error
module rhd_spi_responder
  import rhd_pkg::*;
#(
  parameter int         NUM_CH      = 32,
  parameter logic [7:0] CHIP_ID     = 8'd1,
  parameter int         NUM_RW_REGS = 22
) (
  input  logic        sysclk,
  input  logic        sys_rst_n,
  input  logic        rhd_cs,
  input  logic        rhd_sck,
  input  logic        rhd_mosi,
  output logic        rhd_miso,
  output logic [15:0] cmd_word,
  output logic        cmd_valid,
  output logic        frame_err
);

  localparam int         AW          = $clog2(NUM_RW_REGS);
  localparam logic [6:0] LP_NUM_CH   = 7'(NUM_CH);
  localparam logic [6:0] LP_NUM_RW   = 7'(NUM_RW_REGS);
  localparam logic [5:0] LP_LAST_CH  = 6'(NUM_CH - 1);
  localparam logic [4:0] LP_FRAME    = 5'(FRAME_BITS);

  // Synchronized edge events
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_sck_rise;
  logic w_sck_fall;

  logic r_mosi_meta;
  logic r_mosi_sync;

  rhd_state_e r_state;
  rhd_state_e w_state_nxt;

  // FSM output decodes
  logic w_start;
  logic w_shifting;
  logic w_commit;
  logic w_abort;

  logic        r_armed;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_rx;
  logic [15:0] r_miso_sr;
  logic [15:0] r_slot1;
  logic [15:0] r_slot2;
  logic [15:0] r_cmd_word;
  logic        r_cmd_valid;
  logic        r_frame_err;
  logic [9:0]  r_sample_cnt;
  logic [7:0]  r_regs [NUM_RW_REGS];

  // Command decode of the received word
  logic [1:0]    w_op;
  logic [5:0]    w_addr;
  logic [7:0]    w_data;
  logic [AW-1:0] w_reg_idx;
  logic          w_addr_is_rw;
  logic          w_addr_is_ch;
  logic [7:0]    w_rd_val;
  logic [15:0]   w_result;

  rhd_sync_edge u_sync_cs (
    .i_clk   (sysclk),
    .i_rst_n (sys_rst_n),
    .i_async (rhd_cs),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  rhd_sync_edge u_sync_sck (
    .i_clk   (sysclk),
    .i_rst_n (sys_rst_n),
    .i_async (rhd_sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // MOSI only needs the two-flop synchronizer; it is sampled on SCK rise
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= rhd_mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // FSM state register
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall && r_armed) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cs_rise) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: frame control strobes and the MISO pin
  always_comb begin
    w_start    = 1'b0;
    w_shifting = 1'b0;
    w_commit   = 1'b0;
    w_abort    = 1'b0;
    rhd_miso   = 1'b0;
    case (r_state)
      ST_IDLE:  w_start = w_cs_fall && r_armed;
      ST_SHIFT: begin
        w_shifting = 1'b1;
        rhd_miso   = r_miso_sr[15];
      end
      ST_DONE: begin
        w_commit = (r_bit_cnt == LP_FRAME);
        w_abort  = (r_bit_cnt != LP_FRAME);
      end
      default: ;
    endcase
  end

  // Frame datapath: shift registers, bit counter, result pipeline, strobes.
  // An SCK rise in the same cycle as CS rise is still shifted in, because
  // the DONE decision is taken a cycle later from the updated count.
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_armed     <= 1'b0;
      r_bit_cnt   <= 5'd0;
      r_rx        <= 16'h0000;
      r_miso_sr   <= 16'h0000;
      r_slot1     <= 16'h0000;
      r_slot2     <= 16'h0000;
      r_cmd_word  <= 16'h0000;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_cs_rise) begin
        r_armed <= 1'b1;
      end
      if (w_start) begin
        r_bit_cnt <= 5'd0;
        r_miso_sr <= r_slot2;
      end
      if (w_shifting && w_sck_rise) begin
        r_rx <= {r_rx[14:0], r_mosi_sync};
        if (r_bit_cnt != BIT_CNT_SAT) begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
      if (w_shifting && w_sck_fall) begin
        r_miso_sr <= {r_miso_sr[14:0], 1'b0};
      end
      if (w_commit) begin
        r_cmd_word <= r_rx;
        r_slot2    <= r_slot1;
        r_slot1    <= w_result;
      end
      r_cmd_valid <= w_commit;
      r_frame_err <= w_abort;
    end
  end

  assign cmd_word  = r_cmd_word;
  assign cmd_valid = r_cmd_valid;
  assign frame_err = r_frame_err;

  assign w_op         = r_rx[15:14];
  assign w_addr       = r_rx[13:8];
  assign w_data       = r_rx[7:0];
  assign w_reg_idx    = w_addr[AW-1:0];
  assign w_addr_is_rw = ({1'b0, w_addr} < LP_NUM_RW);
  assign w_addr_is_ch = ({1'b0, w_addr} < LP_NUM_CH);
  assign w_rd_val     = w_addr_is_rw ? r_regs[w_reg_idx]
                                     : rom_value(w_addr, CHIP_ID);

  // Result word for the frame currently held in the receive register
  always_comb begin
    w_result = 16'h0000;
    case (w_op)
      CMD_CONVERT: if (w_addr_is_ch) w_result = {w_addr, r_sample_cnt};
      CMD_WRITE:   w_result = {8'hFF, w_data};
      CMD_READ:    w_result = {8'h00, w_rd_val};
      CMD_CALIB:   w_result = 16'h0000;
      default:     w_result = 16'h0000;
    endcase
  end

  // Writable registers commit in DONE so a READ in the next frame sees them
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_commit && (w_op == CMD_WRITE) && w_addr_is_rw) begin
      r_regs[w_reg_idx] <= w_data;
    end
  end

  // Sample counter advances once per full channel sweep (last channel)
  always_ff @(posedge sysclk) begin
    if (!sys_rst_n) begin
      r_sample_cnt <= 10'd0;
    end else if (w_commit && (w_op == CMD_CONVERT) && (w_addr == LP_LAST_CH)) begin
      r_sample_cnt <= r_sample_cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Self-checking bench for rhd_spi_responder: drives SPI frames from the
// master side and compares MISO against a behavioural command model with
// a two-frame result pipeline.
module tb_rhd_spi_responder;

  logic        sysclk = 1'b0;
  logic        sys_rst_n;
  logic        rhd_cs;
  logic        rhd_sck;
  logic        rhd_mosi;
  logic        rhd_miso;
  logic [15:0] cmd_word;
  logic        cmd_valid;
  logic        frame_err;

  always #5 sysclk = ~sysclk;

  rhd_spi_responder #(
    .NUM_CH      (32),
    .CHIP_ID     (8'd1),
    .NUM_RW_REGS (22)
  ) dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .rhd_cs    (rhd_cs),
    .rhd_sck   (rhd_sck),
    .rhd_mosi  (rhd_mosi),
    .rhd_miso  (rhd_miso),
    .cmd_word  (cmd_word),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  m_regs [64];
  int          m_sample;
  logic [15:0] m_slot1;
  logic [15:0] m_slot2;
  int          exp_valid = 0;
  int          exp_err = 0;
  logic [15:0] exp_last_cmd = 16'h0000;

  // Observed strobe activity
  int          seen_valid = 0;
  int          seen_err = 0;
  logic [15:0] seen_last_cmd = 16'h0000;

  int half_p = 5;
  int gap_p  = 8;

  always @(negedge sysclk) begin
    if (cmd_valid) begin
      seen_valid++;
      seen_last_cmd = cmd_word;
    end
    if (frame_err) seen_err++;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge sysclk);
    #2;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_sample = 0;
    m_slot1  = 16'h0000;
    m_slot2  = 16'h0000;
  endtask

  // Executes one command at the architectural level and returns its result
  task automatic model_exec(input logic [15:0] c, output logic [15:0] r);
    int         op;
    int         a;
    logic [7:0] d;
    string      id;
    op = int'(c[15:14]);
    a  = int'(c[13:8]);
    d  = c[7:0];
    id = "INTAN";
    r  = 16'h0000;
    if (op == 0) begin
      if (a < 32) begin
        r = 16'(a * 1024 + m_sample);
        if (a == 31) m_sample = (m_sample + 1) % 1024;
      end
    end else if (op == 2) begin
      if (a < 22) m_regs[a] = d;
      r = {8'hFF, d};
    end else if (op == 3) begin
      if (a < 22) r = {8'h00, m_regs[a]};
      else if (a >= 40 && a <= 44) r = {8'h00, 8'(id[a-40])};
      else if (a == 63) r = 16'h0001;
    end
  endtask

  // One SPI frame of nbits SCK pulses; rst_bit >= 0 pulses reset mid-frame
  task automatic do_frame(input logic [15:0] cmd, input int nbits,
                          input int rst_bit, output logic [15:0] got);
    logic [15:0] exp_m;
    logic [15:0] res;
    exp_m = m_slot2;
    got   = 16'h0000;
    rhd_cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      rhd_mosi = (i < 16) ? cmd[15-i] : 1'($urandom_range(0, 1));
      if (i == rst_bit) begin
        sys_rst_n = 1'b0;
        clk_wait(3);
        sys_rst_n = 1'b1;
      end
      clk_wait(half_p);
      if (i < 16) got[15-i] = rhd_miso;
      rhd_sck = 1'b1;
      clk_wait(half_p);
      rhd_sck = 1'b0;
    end
    clk_wait(half_p);
    rhd_cs = 1'b1;
    clk_wait(gap_p);
    if (rst_bit >= 0) begin
      model_reset();
    end else if (nbits == 16) begin
      check_val("miso", 32'(got), 32'(exp_m));
      model_exec(cmd, res);
      m_slot2 = m_slot1;
      m_slot1 = res;
      exp_valid++;
      exp_last_cmd = cmd;
    end else begin
      exp_err++;
    end
  endtask

  initial begin
    logic [15:0] g0, g1, g2, g3;
    logic [15:0] sweep_q[$];
    logic [15:0] pre_s2, pre_s1;
    int          v0, e0;
    logic [15:0] rc;
    int          op;

    sys_rst_n = 1'b0;
    rhd_cs    = 1'b1;
    rhd_sck   = 1'b0;
    rhd_mosi  = 1'b0;
    model_reset();
    clk_wait(4);
    check_val("rst_miso", 32'(rhd_miso), 0);
    check_val("rst_cmd_word", 32'(cmd_word), 0);
    check_val("rst_cmd_valid", 32'(cmd_valid), 0);
    check_val("rst_frame_err", 32'(frame_err), 0);
    sys_rst_n = 1'b1;
    clk_wait(10);
    check_val("idle_miso", 32'(rhd_miso), 0);
    check_val("idle_cmd_valid", 32'(seen_valid), 0);

    // ROM reads and pipeline latency
    do_frame(16'hE800, 16, -1, g0);
    do_frame(16'hE900, 16, -1, g1);
    do_frame(16'hFF00, 16, -1, g2);
    do_frame(16'h0000, 16, -1, g3);
    check_val("t1_f1", 32'(g0), 32'h0000);
    check_val("t1_f2", 32'(g1), 32'h0000);
    check_val("t1_f3", 32'(g2), 32'h0049);
    check_val("t1_f4", 32'(g3), 32'h004E);
    clk_wait(10);
    check_val("t1_valid_cnt", 32'(seen_valid), 4);
    check_val("t1_cmd_word", 32'(seen_last_cmd), 32'h0000);

    // Write then read-back
    do_frame(16'h85A5, 16, -1, g0);
    do_frame(16'hC500, 16, -1, g1);
    do_frame(16'h4000, 16, -1, g2);
    do_frame(16'h4000, 16, -1, g3);
    check_val("t2_f3", 32'(g2), 32'hFFA5);
    check_val("t2_f4", 32'(g3), 32'h00A5);

    // Two full channel sweeps
    for (int pass = 0; pass < 2; pass++) begin
      for (int ch = 0; ch < 32; ch++) begin
        do_frame({2'b00, 6'(ch), 8'h00}, 16, -1, g0);
        sweep_q.push_back(g0);
      end
    end
    do_frame(16'h4000, 16, -1, g0);
    sweep_q.push_back(g0);
    do_frame(16'h4000, 16, -1, g0);
    sweep_q.push_back(g0);
    for (int j = 0; j < 64; j++) begin
      check_val("sweep", 32'(sweep_q[j+2]), 32'({6'(j % 32), 10'(j / 32)}));
    end

    // Out-of-range channel
    do_frame(16'hFF00, 16, -1, g0);
    do_frame(16'h2800, 16, -1, g1);
    do_frame(16'h4000, 16, -1, g2);
    do_frame(16'h4000, 16, -1, g3);
    check_val("t3_chipid", 32'(g2), 32'h0001);
    check_val("t3_conv40", 32'(g3), 32'h0000);

    // Aborted frames must not disturb the pipeline
    do_frame(16'h833C, 16, -1, g0);
    do_frame(16'hE900, 16, -1, g0);
    clk_wait(10);
    pre_s2 = m_slot2;
    pre_s1 = m_slot1;
    v0 = seen_valid;
    e0 = seen_err;
    do_frame(16'hC300, 9, -1, g0);
    clk_wait(10);
    check_val("abort_err_cnt", 32'(seen_err - e0), 1);
    check_val("abort_valid_cnt", 32'(seen_valid - v0), 0);
    do_frame(16'h4000, 16, -1, g0);
    do_frame(16'h4000, 16, -1, g1);
    check_val("abort_f1", 32'(g0), 32'hFF3C);
    check_val("abort_f2", 32'(g1), 32'h004E);
    check_val("abort_model", 32'({g0, g1}), 32'({pre_s2, pre_s1}));
    e0 = seen_err;
    do_frame(16'hC300, 17, -1, g0);
    clk_wait(10);
    check_val("long_err_cnt", 32'(seen_err - e0), 1);

    // Reset in the middle of a frame
    do_frame(16'h8777, 16, -1, g0);
    clk_wait(10);
    v0 = seen_valid;
    e0 = seen_err;
    do_frame(16'hC700, 16, 7, g0);
    clk_wait(10);
    check_val("rst_mid_valid", 32'(seen_valid - v0), 0);
    check_val("rst_mid_err", 32'(seen_err - e0), 0);
    do_frame(16'hC700, 16, -1, g0);
    check_val("rst_first", 32'(g0), 32'h0000);
    do_frame(16'h4000, 16, -1, g0);
    do_frame(16'h4000, 16, -1, g0);
    check_val("rst_reg_cleared", 32'(g0), 32'h0000);

    // Random commands at minimum SCK and CS-gap timing
    half_p = 4;
    gap_p  = 4;
    for (int k = 0; k < 100; k++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0) rc = {2'b00, 6'($urandom_range(0, 35)), 8'($urandom)};
      else rc = {2'(op), 6'($urandom_range(0, 63)), 8'($urandom)};
      do_frame(rc, 16, -1, g0);
    end
    do_frame(16'h4000, 16, -1, g0);
    do_frame(16'h4000, 16, -1, g0);
    clk_wait(10);
    check_val("total_valid", 32'(seen_valid), 32'(exp_valid));
    check_val("total_err", 32'(seen_err), 32'(exp_err));
    check_val("last_cmd_word", 32'(seen_last_cmd), 32'(exp_last_cmd));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
